// File: rtl/mips_mem_pkg.sv
// Shared encodings for the load/store unit: access opcodes, controller FSM states
// and the misalignment rule used by the optional trap path.
package mips_mem_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] lo);
        case (op)
            OP_LW, OP_SW:         return lo != 2'b00;
            OP_LH, OP_LHU, OP_SH: return lo[0];
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Big-endian byte-lane steering: extracts/extends sub-word load data and merges
// sub-word store data into a previously read word.
module lsu_lane_align
    import mips_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  op,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  lane      [4];
    logic [7:0]  st_lane   [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane 0 is the most significant byte of the word.
    for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
        localparam logic [1:0] LANE = 2'(gi);
        assign lane[gi] = word[31-8*gi -: 8];
        assign st_lane[gi] =
            (op == OP_SB && offset == LANE)      ? wdata[7:0] :
            (op == OP_SH && offset[1] == LANE[1]) ? (LANE[0] ? wdata[7:0] : wdata[15:8]) :
                                                    lane[gi];
    end

    assign store_word = {st_lane[0], st_lane[1], st_lane[2], st_lane[3]};
    assign byte_sel   = lane[offset];
    assign half_sel   = offset[1] ? word[15:0] : word[31:16];

    always_comb begin
        load_data = word;
        case (op)
            OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  load_data = {24'd0, byte_sel};
            OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  load_data = {16'd0, half_sel};
            default: load_data = word;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator between the MEM stage and a word-wide big-endian memory.
// Define MISALIGN_TRAP_EN to report misaligned accesses via resp_err instead of truncating.
module lsu_mem_ctrl
    import mips_mem_pkg::*;
#(
    parameter int ADDR_BITS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_writeData,
    output logic        mem_memwrite,
    output logic        mem_memread,
    input  logic [31:0] mem_out32
);

    state_e                 state_reg, state_next;
    logic [2:0]             op_reg;
    logic [ADDR_BITS-1:0]   addr_reg;
    logic [31:0]            wdata_reg;
    logic [31:0]            word_reg;
    logic [1:0]             offset;
    logic [31:0]            load_data;
    logic [31:0]            store_word;
    logic                   accept;
    logic                   is_store;
    logic                   unused_addr_bits;

    assign unused_addr_bits = ^req_addr[31:ADDR_BITS];
    assign accept   = (state_reg == ST_IDLE) && req_valid;
    assign is_store = (op_reg == OP_SW) || (op_reg == OP_SH) || (op_reg == OP_SB);

    // Alignment masking is a no-op for aligned requests, so it is safe in both builds.
    always_comb begin
        offset = addr_reg[1:0];
        if (op_reg == OP_LW || op_reg == OP_SW)
            offset = 2'b00;
        else if (op_reg == OP_LH || op_reg == OP_LHU || op_reg == OP_SH)
            offset[0] = 1'b0;
    end

    lsu_lane_align u_align (
        .word       (word_reg),
        .offset     (offset),
        .op         (op_reg),
        .wdata      (wdata_reg),
        .load_data  (load_data),
        .store_word (store_word)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            op_reg    <= 3'd0;
            addr_reg  <= '0;
            wdata_reg <= 32'd0;
            word_reg  <= 32'd0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                op_reg    <= req_op;
                addr_reg  <= req_addr[ADDR_BITS-1:0];
                wdata_reg <= req_wdata;
            end
            if (state_reg == ST_READ)
                word_reg <= mem_out32;
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic err_reg;

    always_ff @(posedge clk) begin
        if (!rst_n)
            err_reg <= 1'b0;
        else if (accept)
            err_reg <= is_misaligned(req_op, req_addr[1:0]);
    end

    assign resp_err = (state_reg == ST_RESP) && err_reg;
`else
    logic err_reg;
    assign err_reg  = 1'b0;
    assign resp_err = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req_valid) begin
`ifdef MISALIGN_TRAP_EN
                    if (is_misaligned(req_op, req_addr[1:0]))
                        state_next = ST_RESP;
                    else
`endif
                    if (req_op == OP_SW)
                        state_next = ST_WRITE;
                    else
                        state_next = ST_READ;
                end
            end
            ST_READ:  state_next = (op_reg == OP_SH || op_reg == OP_SB) ? ST_WRITE : ST_RESP;
            ST_WRITE: state_next = ST_RESP;
            ST_RESP:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // The write strobe is gated by rst_n so a reset landing on WRITE never commits.
    always_comb begin
        req_ready     = (state_reg == ST_IDLE);
        mem_memread   = (state_reg == ST_READ);
        mem_memwrite  = (state_reg == ST_WRITE) && rst_n;
        mem_address   = 32'd0;
        mem_writeData = 32'd0;
        resp_valid    = (state_reg == ST_RESP);
        resp_rdata    = 32'd0;
        if (state_reg == ST_READ || state_reg == ST_WRITE)
            mem_address = {{(32-ADDR_BITS){1'b0}}, addr_reg[ADDR_BITS-1:2], 2'b00};
        if (state_reg == ST_WRITE)
            mem_writeData = (op_reg == OP_SW) ? wdata_reg : store_word;
        if (state_reg == ST_RESP && !is_store && !err_reg)
            resp_rdata = load_data;
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a behavioural 256-byte big-endian memory.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_writeData;
    logic        mem_memwrite;
    logic        mem_memread;
    logic [31:0] mem_out32;

    logic [31:0] mem [64];
    logic        mem_init = 1'b1;

    int n_cmp = 0;
    int n_err = 0;
    int overlap = 0;

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.ADDR_BITS(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_err      (resp_err),
        .mem_address   (mem_address),
        .mem_writeData (mem_writeData),
        .mem_memwrite  (mem_memwrite),
        .mem_memread   (mem_memread),
        .mem_out32     (mem_out32)
    );

    assign mem_out32 = mem[mem_address[7:2]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'd0;
            mem[0]  <= 32'h0043_0822;
            mem[1]  <= 32'h8CA4_0006;
            mem[63] <= 32'h1111_1111;
        end else if (mem_memwrite) begin
            mem[mem_address[7:2]] <= mem_writeData;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one access from a negedge and collects everything seen until the response.
    task automatic run_op(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat,
                          output int nrd, output int nwr, output logic [31:0] wd,
                          output logic [31:0] wa);
        int n = 0;
        rdata = 32'd0; err = 1'b0; lat = 0; nrd = 0; nwr = 0; wd = 32'd0; wa = 32'd0;
        while (!req_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        check_eq("ready_before_req", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (mem_memread) nrd++;
            if (mem_memwrite) begin
                nwr++;
                wd = mem_writeData;
                wa = mem_address;
            end
            if (mem_memread && mem_memwrite) overlap++;
            if (resp_valid) begin
                lat = i;
                rdata = resp_rdata;
                err = resp_err;
                break;
            end
        end
        @(negedge clk);
        check_eq("resp_one_pulse", {31'd0, resp_valid}, 32'd0);
        check_eq("ready_after_resp", {31'd0, req_ready}, 32'd1);
        $display("op=%0d addr=%h wdata=%h -> rdata=%h err=%b lat=%0d rd=%0d wr=%0d",
                 op, addr, wdata, rdata, err, lat, nrd, nwr);
    endtask

    logic [31:0] rd, wd, wa;
    logic        er;
    int          lat, nrd, nwr;

    initial begin
        repeat (3) @(negedge clk);
        check_eq("rst_ready", {31'd0, req_ready}, 32'd1);
        check_eq("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check_eq("rst_rdata", resp_rdata, 32'd0);
        check_eq("rst_err", {31'd0, resp_err}, 32'd0);
        check_eq("rst_strobes", {30'd0, mem_memread, mem_memwrite}, 32'd0);
        check_eq("rst_address", mem_address, 32'd0);
        check_eq("rst_wdata", mem_writeData, 32'd0);
        mem_init = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        run_op(3'd3, 32'd1, 32'd0, rd, er, lat, nrd, nwr, wd, wa);
        check_eq("lb1_data", rd, 32'h0000_0043);
        check_eq("lb1_lat", lat, 32'd2);
        check_eq("lb1_nowrite", nwr, 32'd0);

        run_op(3'd3, 32'd4, 32'd0, rd, er, lat, nrd, nwr, wd, wa);
        check_eq("lb4_data", rd, 32'hFFFF_FF8C);
        run_op(3'd4, 32'd4, 32'd0, rd, er, lat, nrd, nwr, wd, wa);
        check_eq("lbu4_data", rd, 32'h0000_008C);
        run_op(3'd1, 32'd4, 32'd0, rd, er, lat, nrd, nwr, wd, wa);
        check_eq("lh4_data", rd, 32'hFFFF_8CA4);
        check_eq("lh4_lat", lat, 32'd2);
        run_op(3'd2, 32'd6, 32'd0, rd, er, lat, nrd, nwr, wd, wa);
        check_eq("lhu6_data", rd, 32'h0000_0006);

        run_op(3'd7, 32'd253, 32'h0000_00AB, rd, er, lat, nrd, nwr, wd, wa);
        check_eq("sb_nwrite", nwr, 32'd1);
        check_eq("sb_wdata", wd, 32'h11AB_1111);
        check_eq("sb_lat", lat, 32'd3);
        check_eq("sb_rdata", rd, 32'd0);
        run_op(3'd0, 32'd252, 32'd0, rd, er, lat, nrd, nwr, wd, wa);
        check_eq("lw252_data", rd, 32'h11AB_1111);

        run_op(3'd5, 32'd8, 32'hDEAD_BEEF, rd, er, lat, nrd, nwr, wd, wa);
        check_eq("sw_nread", nrd, 32'd0);
        check_eq("sw_nwrite", nwr, 32'd1);
        check_eq("sw_addr", wa, 32'd8);
        check_eq("sw_lat", lat, 32'd2);
        run_op(3'd1, 32'd10, 32'd0, rd, er, lat, nrd, nwr, wd, wa);
        check_eq("lh10_data", rd, 32'hFFFF_BEEF);

        // SH interrupted by reset while in WRITE.
        req_valid = 1'b1; req_op = 3'd6; req_addr = 32'd0; req_wdata = 32'h0000_1234;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("sh_in_write", {31'd0, mem_memwrite}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("rstw_memwrite", {31'd0, mem_memwrite}, 32'd0);
        check_eq("rstw_ready", {31'd0, req_ready}, 32'd1);
        check_eq("rstw_resp", {31'd0, resp_valid}, 32'd0);
        check_eq("rstw_mem", mem[0], 32'h0043_0822);
        $display("reset during SH write: memwrite=%b ready=%b word0=%h", mem_memwrite, req_ready, mem[0]);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(3'd0, 32'd2, 32'd0, rd, er, lat, nrd, nwr, wd, wa);
`ifdef MISALIGN_TRAP_EN
        check_eq("mis_err", {31'd0, er}, 32'd1);
        check_eq("mis_lat", lat, 32'd1);
        check_eq("mis_strobes", nrd + nwr, 32'd0);
        check_eq("mis_rdata", rd, 32'd0);
`else
        check_eq("mis_data", rd, 32'h0043_0822);
        check_eq("mis_err", {31'd0, er}, 32'd0);
        check_eq("mis_lat", lat, 32'd2);
`endif

        check_eq("no_rd_wr_overlap", overlap, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
